register_scoreboard: RTL and testbench

Tracks outstanding register writes for the in-order issue stage. It produces the register-hazard stall term that the stall controller ORs into the global stall enable. Each architectural register has a small saturating pending-write counter. Counters increment when an instruction with a destination actually issues and decrement when a writeback port retires that register. The block flags RAW hazards on source operands and stops WAW overflow on the destination.

---
 rtl/register_scoreboard.sv | 99 +++++++++
 tb/tb_register_scoreboard.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/register_scoreboard.sv
// Per-register saturating pending-write counters for the in-order issue stage.
// Stall output is combinational from decode inputs and registered counts; counts update one edge after issue/writeback.
module register_scoreboard #(
    parameter int REGCOUNT     = 16,
    parameter int REGADDRWIDTH = 4,
    parameter int MAXPENDING   = 3
) (
    input  logic                    clk,
    input  logic                    async_rst,
    input  logic                    clk_en,
    input  logic                    InstructionValid,
    input  logic                    SrcAValid,
    input  logic [REGADDRWIDTH-1:0] SrcAAddr,
    input  logic                    SrcBValid,
    input  logic [REGADDRWIDTH-1:0] SrcBAddr,
    input  logic                    DestValid,
    input  logic [REGADDRWIDTH-1:0] DestAddr,
    input  logic                    IssueEn,
    input  logic                    WbAValid,
    input  logic [REGADDRWIDTH-1:0] WbAAddr,
    input  logic                    WbBValid,
    input  logic [REGADDRWIDTH-1:0] WbBAddr,
    output logic                    RegisterStallOut,
    output logic [REGCOUNT-1:0]     PendingMask,
    output logic                    Idle,
    output logic                    ScoreboardError
);
    localparam int CW = $clog2(MAXPENDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAXPENDING);
    localparam logic [CW:0]   MAX_EXT = (CW + 1)'(MAXPENDING);

    logic [CW-1:0] count_q [REGCOUNT];
    logic [CW-1:0] count_d [REGCOUNT];
    logic          err_q;
    logic          err_d;

    logic raw_a;
    logic raw_b;
    logic waw_full;

    // Register 0 is never written, so its count stays zero and hazard lookups on it never fire.
    assign raw_a    = SrcAValid && (count_q[SrcAAddr] != '0);
    assign raw_b    = SrcBValid && (count_q[SrcBAddr] != '0);
    assign waw_full = DestValid && (count_q[DestAddr] == MAX_CNT);
    assign RegisterStallOut = InstructionValid && (raw_a || raw_b || waw_full);

    always_comb begin
        PendingMask = '0;
        for (int i = 0; i < REGCOUNT; i++) begin
            PendingMask[i] = (count_q[i] != '0);
        end
    end

    assign Idle            = ~|PendingMask;
    assign ScoreboardError = err_q;

    always_comb begin
        count_d    = count_q;
        count_d[0] = '0;
        err_d      = err_q;
        for (int i = 1; i < REGCOUNT; i++) begin
            logic          inc_v;
            logic          wa_hit;
            logic          wb_hit;
            logic [CW:0]   sum_v;
            logic [CW:0]   dec_v;
            logic [CW:0]   diff_v;
            inc_v  = IssueEn && DestValid && (DestAddr == REGADDRWIDTH'(i));
            wa_hit = WbAValid && (WbAAddr == REGADDRWIDTH'(i));
            wb_hit = WbBValid && (WbBAddr == REGADDRWIDTH'(i));
            sum_v  = {1'b0, count_q[i]} + (CW + 1)'(inc_v);
            dec_v  = (CW + 1)'(wa_hit) + (CW + 1)'(wb_hit);
            diff_v = sum_v - dec_v;
            if (clk_en) begin
                if (sum_v < dec_v) begin
                    count_d[i] = '0;
                    err_d      = 1'b1;
                end else if (diff_v > MAX_EXT) begin
                    count_d[i] = MAX_CNT;
                    err_d      = 1'b1;
                end else begin
                    count_d[i] = diff_v[CW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            for (int i = 0; i < REGCOUNT; i++) begin
                count_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_register_scoreboard.sv
// Directed table-driven bench for register_scoreboard plus hand sequences for reset and overflow.
module tb_register_scoreboard;
    logic        clk = 1'b0;
    logic        async_rst = 1'b0;
    logic        clk_en;
    logic        InstructionValid;
    logic        SrcAValid, SrcBValid, DestValid, IssueEn, WbAValid, WbBValid;
    logic [3:0]  SrcAAddr, SrcBAddr, DestAddr, WbAAddr, WbBAddr;
    logic        RegisterStallOut;
    logic [15:0] PendingMask;
    logic        Idle;
    logic        ScoreboardError;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    register_scoreboard #(.REGCOUNT(16), .REGADDRWIDTH(4), .MAXPENDING(3)) dut (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
        .InstructionValid(InstructionValid),
        .SrcAValid(SrcAValid), .SrcAAddr(SrcAAddr),
        .SrcBValid(SrcBValid), .SrcBAddr(SrcBAddr),
        .DestValid(DestValid), .DestAddr(DestAddr),
        .IssueEn(IssueEn),
        .WbAValid(WbAValid), .WbAAddr(WbAAddr),
        .WbBValid(WbBValid), .WbBAddr(WbBAddr),
        .RegisterStallOut(RegisterStallOut), .PendingMask(PendingMask),
        .Idle(Idle), .ScoreboardError(ScoreboardError)
    );

    typedef struct {
        logic        en, iv, sav;
        logic [3:0]  saa;
        logic        sbv;
        logic [3:0]  sba;
        logic        dv;
        logic [3:0]  da;
        logic        iss, wav;
        logic [3:0]  waa;
        logic        wbv;
        logic [3:0]  wba;
        logic        x_stall;
        logic [15:0] x_mask;
        logic        x_idle, x_err;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    function automatic vec_t mk(input int en, iv, sav, saa, sbv, sba, dv, da, iss,
                                input int wav, waa, wbv, wba, stall, mask, idle, err);
        vec_t v;
        v.en = 1'(en);   v.iv = 1'(iv);   v.sav = 1'(sav); v.saa = 4'(saa);
        v.sbv = 1'(sbv); v.sba = 4'(sba); v.dv = 1'(dv);   v.da = 4'(da);
        v.iss = 1'(iss); v.wav = 1'(wav); v.waa = 4'(waa); v.wbv = 1'(wbv);
        v.wba = 4'(wba); v.x_stall = 1'(stall); v.x_mask = 16'(mask);
        v.x_idle = 1'(idle); v.x_err = 1'(err);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        clk_en = v.en; InstructionValid = v.iv;
        SrcAValid = v.sav; SrcAAddr = v.saa; SrcBValid = v.sbv; SrcBAddr = v.sba;
        DestValid = v.dv; DestAddr = v.da; IssueEn = v.iss;
        WbAValid = v.wav; WbAAddr = v.waa; WbBValid = v.wbv; WbBAddr = v.wba;
    endtask

    task automatic clr();
        drive(mk(1, 0,0,0, 0,0, 0,0, 0, 0,0, 0,0, 0,0,0,0));
    endtask

    task automatic issue(input int d);
        drive(mk(1, 1,0,0, 0,0, 1,d, 1, 0,0, 0,0, 0,0,0,0));
    endtask

    initial begin
        // en iv sav saa sbv sba dv da iss wav waa wbv wba | stall mask idle err
        tbl[0]  = mk(1, 0,0,0, 0,0, 0,0, 0, 0,0, 0,0,  0, 16'h0000, 1, 0);
        tbl[1]  = mk(1, 1,0,0, 0,0, 1,5, 1, 0,0, 0,0,  0, 16'h0000, 1, 0);
        tbl[2]  = mk(1, 1,1,5, 0,0, 0,0, 0, 1,5, 0,0,  1, 16'h0020, 0, 0);
        tbl[3]  = mk(1, 1,1,5, 0,0, 0,0, 0, 0,0, 0,0,  0, 16'h0000, 1, 0);
        tbl[4]  = mk(1, 1,0,0, 0,0, 1,3, 1, 0,0, 0,0,  0, 16'h0000, 1, 0);
        tbl[5]  = mk(1, 1,0,0, 0,0, 1,3, 1, 0,0, 0,0,  0, 16'h0008, 0, 0);
        tbl[6]  = mk(1, 1,0,0, 0,0, 1,3, 1, 0,0, 0,0,  0, 16'h0008, 0, 0);
        tbl[7]  = mk(1, 1,0,0, 0,0, 1,3, 0, 0,0, 1,3,  1, 16'h0008, 0, 0);
        tbl[8]  = mk(1, 1,0,0, 0,0, 1,3, 0, 0,0, 0,0,  0, 16'h0008, 0, 0);
        tbl[9]  = mk(1, 0,0,0, 0,0, 0,0, 0, 1,3, 1,3,  0, 16'h0008, 0, 0);
        tbl[10] = mk(1, 0,0,0, 0,0, 0,0, 0, 0,0, 0,0,  0, 16'h0000, 1, 0);
        tbl[11] = mk(1, 1,0,0, 0,0, 1,7, 1, 0,0, 0,0,  0, 16'h0000, 1, 0);
        tbl[12] = mk(1, 1,0,0, 0,0, 1,7, 1, 1,7, 0,0,  0, 16'h0080, 0, 0);
        tbl[13] = mk(1, 1,0,0, 1,7, 0,0, 0, 1,7, 0,0,  1, 16'h0080, 0, 0);
        tbl[14] = mk(1, 1,0,0, 0,0, 1,9, 1, 0,0, 0,0,  0, 16'h0000, 1, 0);
        tbl[15] = mk(1, 1,0,0, 0,0, 1,9, 1, 0,0, 0,0,  0, 16'h0200, 0, 0);
        tbl[16] = mk(1, 0,1,9, 0,0, 0,0, 0, 1,9, 1,9,  0, 16'h0200, 0, 0);
        tbl[17] = mk(1, 1,1,0, 0,0, 1,0, 1, 0,0, 0,0,  0, 16'h0000, 1, 0);
        tbl[18] = mk(1, 1,1,0, 0,0, 0,0, 0, 0,0, 0,0,  0, 16'h0000, 1, 0);
        tbl[19] = mk(1, 0,0,0, 0,0, 0,0, 0, 1,4, 0,0,  0, 16'h0000, 1, 0);
        tbl[20] = mk(1, 0,0,0, 0,0, 0,0, 0, 0,0, 0,0,  0, 16'h0000, 1, 1);
        tbl[21] = mk(1, 1,0,0, 0,0, 1,2, 1, 0,0, 0,0,  0, 16'h0000, 1, 1);
        tbl[22] = mk(0, 1,1,2, 0,0, 1,2, 1, 1,2, 0,0,  1, 16'h0004, 0, 1);
        tbl[23] = mk(0, 1,1,6, 0,0, 1,2, 1, 0,0, 0,0,  0, 16'h0004, 0, 1);
        tbl[24] = mk(1, 1,1,2, 0,0, 0,0, 0, 1,2, 0,0,  1, 16'h0004, 0, 1);
        tbl[25] = mk(1, 0,0,0, 0,0, 0,0, 0, 0,0, 0,0,  0, 16'h0000, 1, 1);

        clr();
        #2 async_rst = 1'b1;
        #1;
        chk("rst_idle",  32'(Idle), 32'd1);
        chk("rst_mask",  32'(PendingMask), 32'h0);
        chk("rst_stall", 32'(RegisterStallOut), 32'd0);
        chk("rst_err",   32'(ScoreboardError), 32'd0);
        @(negedge clk) async_rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(tbl[k]);
            #1;
            chk($sformatf("v%0d_stall", k), 32'(RegisterStallOut), 32'(tbl[k].x_stall));
            chk($sformatf("v%0d_mask", k),  32'(PendingMask),      32'(tbl[k].x_mask));
            chk($sformatf("v%0d_idle", k),  32'(Idle),             32'(tbl[k].x_idle));
            chk($sformatf("v%0d_err", k),   32'(ScoreboardError),  32'(tbl[k].x_err));
        end

        // Reset asserted between edges with an outstanding write and a sticky error.
        @(negedge clk) issue(5);
        @(posedge clk); #2;
        clr(); InstructionValid = 1'b1; SrcAValid = 1'b1; SrcAAddr = 4'd5;
        #1 chk("pre_rst_stall", 32'(RegisterStallOut), 32'd1);
        async_rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(RegisterStallOut), 32'd0);
        chk("mid_rst_mask",  32'(PendingMask), 32'h0);
        chk("mid_rst_idle",  32'(Idle), 32'd1);
        chk("mid_rst_err",   32'(ScoreboardError), 32'd0);
        @(negedge clk);
        async_rst = 1'b0;
        clr(); WbBValid = 1'b1; WbBAddr = 4'd6;
        @(posedge clk); #1;
        chk("post_rst_underflow_err",  32'(ScoreboardError), 32'd1);
        chk("post_rst_underflow_mask", 32'(PendingMask), 32'h0);

        // Forced fourth issue past MAXPENDING must clamp at 3 and flag an error.
        @(negedge clk) async_rst = 1'b1;
        #1 async_rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk) issue(11);
            #1;
            if (n == 3) chk("ovf_waw_stall", 32'(RegisterStallOut), 32'd1);
            else        chk($sformatf("ovf_no_stall%0d", n), 32'(RegisterStallOut), 32'd0);
        end
        @(negedge clk) clr();
        #1;
        chk("ovf_err",  32'(ScoreboardError), 32'd1);
        chk("ovf_mask", 32'(PendingMask), 32'h0800);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk) begin clr(); WbAValid = 1'b1; WbAAddr = 4'd11; end
            #1 chk($sformatf("ovf_drain%0d", n), 32'(PendingMask), 32'h0800);
        end
        @(negedge clk) clr();
        #1;
        chk("ovf_drained_mask", 32'(PendingMask), 32'h0);
        chk("ovf_drained_idle", 32'(Idle), 32'd1);
        chk("ovf_err_sticky",   32'(ScoreboardError), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
